// File: rtl/conv_out_packer.sv
// Output packer for the conv/quant/maxpool datapath.
// Gathers eight 64-bit words (8 x int8 each) into one 512-bit AXI-Stream beat,
// buffers beats in a first-word-fall-through FIFO and flags the final beat of a run.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start; input words are ignored
// S_RUN   | packing words into lanes and pushing completed beats
// S_DRAIN | all words consumed; waiting for the FIFO to empty downstream
// S_DONE  | one-cycle done pulse, then back to idle
module conv_out_packer #(
   parameter int FIFO_DEPTH = 64,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CNT_WIDTH-1:0] cfg_num_words,
   input  logic                 start,
   input  logic [63:0]          in_data,
   input  logic                 in_valid,
   output logic [511:0]         m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow
);

   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int FIFO_W = 513;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]           r_state;
   logic [CNT_WIDTH-1:0] r_remaining;
   logic [2:0]           r_idx;
   logic [511:0]         r_beat;
   logic [AW:0]          r_wr_ptr;
   logic [AW:0]          r_rd_ptr;
   logic                 r_overflow;
   logic [FIFO_W-1:0]    r_mem [FIFO_DEPTH];

   logic                 w_empty;
   logic                 w_full;
   logic [AW:0]          w_count;
   logic                 w_pop;
   logic                 w_word;
   logic                 w_final;
   logic                 w_push;
   logic                 w_push_ok;
   logic                 w_drop;
   logic [511:0]         w_beat;
   logic [FIFO_W-1:0]    w_head;
   logic [AW-1:0]        w_wr_prev;

   // FIFO status from the extra pointer MSB; pointers wrap naturally
   always_comb begin
      w_empty   = (r_wr_ptr == r_rd_ptr);
      w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
      w_count   = r_wr_ptr - r_rd_ptr;
      w_pop     = !w_empty && m_axis_tready;
      w_head    = r_mem[r_rd_ptr[AW-1:0]];
      w_wr_prev = r_wr_ptr[AW-1:0] - AW'(1);
   end

   // Lane assembly: higher lanes of r_beat are always zero, so padding is free
   always_comb begin
      w_word    = (r_state == S_RUN) && in_valid;
      w_final   = w_word && (r_remaining == CNT_WIDTH'(1));
      w_push    = w_word && ((r_idx == 3'd7) || w_final);
      // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands
      w_push_ok = w_push && (!w_full || w_pop);
      w_drop    = w_push && !w_push_ok;
      w_beat    = r_beat;
      w_beat[{r_idx, 6'd0} +: 64] = in_data;
   end

   // FIFO storage; a dropped final beat moves the last marker onto the newest stored entry
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {w_final, w_beat};
      end else if (w_drop && w_final) begin
         r_mem[w_wr_prev][FIFO_W-1] <= 1'b1;
      end
   end

   // Control FSM, lane packer, FIFO pointers and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_idx       <= '0;
         r_beat      <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         if (w_drop)    r_overflow <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_remaining <= cfg_num_words;
                  r_idx       <= '0;
                  r_beat      <= '0;
                  // An empty run still passes through drain so done keeps a fixed two-cycle latency
                  r_state     <= (cfg_num_words == '0) ? S_DRAIN : S_RUN;
               end
            end
            S_RUN: begin
               if (w_word) begin
                  r_remaining <= r_remaining - CNT_WIDTH'(1);
                  if (w_push) begin
                     r_idx  <= '0;
                     r_beat <= '0;
                     if (w_final) r_state <= S_DRAIN;
                  end else begin
                     r_idx  <= r_idx + 3'd1;
                     r_beat <= w_beat;
                  end
               end
            end
            S_DRAIN: begin
               // Leave on the handshake of the last entry so done follows it by one cycle
               if (w_empty || ((w_count == (AW+1)'(1)) && w_pop)) r_state <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs; head data is masked while empty so stale entries never show
   always_comb begin
      m_axis_tvalid = !w_empty;
      m_axis_tdata  = w_empty ? '0 : w_head[511:0];
      m_axis_tlast  = !w_empty && w_head[FIFO_W-1];
      busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
      done          = (r_state == S_DONE);
      overflow      = r_overflow;
   end

endmodule

// File: tb/tb_conv_out_packer.sv
// Self-checking bench for conv_out_packer: a word-level model fills a beat
// scoreboard, a watcher pops and compares beats as the DUT hands them over.
module tb_conv_out_packer;

   localparam int DEPTH = 64;

   logic         clk;
   logic         rst;
   logic [31:0]  cfg_num_words;
   logic         start;
   logic [63:0]  in_data;
   logic         in_valid;
   logic [511:0] m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tready;
   logic         m_axis_tlast;
   logic         busy;
   logic         done;
   logic         overflow;

   logic [512:0] sb [$];
   logic [63:0]  wq [$];
   int           n_tests;
   int           n_fail;

   conv_out_packer #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_num_words (cfg_num_words),
      .start         (start),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .busy          (busy),
      .done          (done),
      .overflow      (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference packing: 8 words per beat, zero padding, last flag on the run's final beat
   task automatic model_beats(input int cfg);
      logic [511:0] beat;
      int           lane;
      int           n;
      beat = '0;
      lane = 0;
      n = (cfg < wq.size()) ? cfg : wq.size();
      for (int i = 0; i < n; i++) begin
         beat[64*lane +: 64] = wq[i];
         lane++;
         if (lane == 8 || i == cfg - 1) begin
            sb.push_back({(i == cfg - 1) ? 1'b1 : 1'b0, beat});
            beat = '0;
            lane = 0;
         end
      end
   endtask

   task automatic start_run(input int cfg);
      cfg_num_words = cfg;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drive_words(input bit gaps);
      for (int i = 0; i < wq.size(); i++) begin
         while (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
            tick();
         end
         in_data  = wq[i];
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   // Watches the stream until done: scoreboard compare, stall stability, done latency
   task automatic watch(input string name, input int budget);
      int           c;
      int           n_done;
      int           last_hs;
      bit           prev_stall;
      logic [512:0] prev;
      logic [512:0] exp;
      c = 0;
      n_done = 0;
      last_hs = -10;
      prev_stall = 1'b0;
      prev = '0;
      while (c < budget && n_done == 0) begin
         @(negedge clk);
         c++;
         if (prev_stall) begin
            n_tests++;
            if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== prev) begin
               n_fail++;
               $display("FAIL %s stall_stable: got v=%b %h required v=1 %h", name,
                        m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, prev);
            end
         end
         if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL %s unexpected_beat: got %h required none", name, m_axis_tdata);
            end else begin
               exp = sb.pop_front();
               if ({m_axis_tlast, m_axis_tdata} !== exp) begin
                  n_fail++;
                  $display("FAIL %s beat: got %h required %h", name,
                           {m_axis_tlast, m_axis_tdata}, exp);
               end
               if (exp[512]) last_hs = c;
            end
         end
         if (done === 1'b1) begin
            n_done++;
            n_tests++;
            if (last_hs != c - 1) begin
               n_fail++;
               $display("FAIL %s done_latency: got done at %0d required %0d", name, c, last_hs + 1);
            end
         end
         prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
         prev = {m_axis_tlast, m_axis_tdata};
      end
      n_tests++;
      if (n_done == 0) begin
         n_fail++;
         $display("FAIL %s done_timeout: got no done in %0d cycles required done", name, budget);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if (done !== 1'b0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_done: got done=%b busy=%b tvalid=%b required 0 0 0",
                     name, done, busy, m_axis_tvalid);
         end
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s missing_beats: got %0d left required 0", name, sb.size());
      end
      sb.delete();
   endtask

   task automatic check_idle_outputs(input string name);
      @(negedge clk);
      n_tests++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || overflow !== 1'b0 || m_axis_tdata !== '0) begin
         n_fail++;
         $display("FAIL %s outputs: got v=%b l=%b busy=%b done=%b ovf=%b data_nz=%b required all 0",
                  name, m_axis_tvalid, m_axis_tlast, busy, done, overflow, |m_axis_tdata);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      check_idle_outputs("reset");
      tick();
      rst = 1'b0;
   endtask

   task automatic test_basic16();
      wq.delete();
      for (int i = 1; i <= 16; i++) wq.push_back(64'(i));
      model_beats(16);
      m_axis_tready = 1'b1;
      start_run(16);
      fork
         drive_words(1'b0);
         watch("basic16", 200);
      join
   endtask

   task automatic test_partial10();
      wq.delete();
      for (int i = 1; i <= 10; i++) wq.push_back({32'hA5A5_0000, 32'(i)});
      model_beats(10);
      m_axis_tready = 1'b1;
      start_run(10);
      fork
         drive_words(1'b0);
         watch("partial10", 200);
      join
   endtask

   task automatic test_overflow();
      logic [512:0] tmp;
      int           nw;
      nw = 8 * (DEPTH + 1);
      wq.delete();
      for (int i = 0; i < nw; i++) wq.push_back({32'(i), 32'hC0DE_0000 + 32'(i)});
      model_beats(nw);
      void'(sb.pop_back());
      tmp = sb.pop_back();
      tmp[512] = 1'b1;
      sb.push_back(tmp);
      m_axis_tready = 1'b0;
      start_run(nw);
      fork
         begin
            for (int i = 0; i < nw; i++) begin
               in_data  = wq[i];
               in_valid = 1'b1;
               @(negedge clk);
               if (i == nw - 1 || i == nw - 9) begin
                  n_tests++;
                  if (overflow !== 1'b0) begin
                     n_fail++;
                     $display("FAIL overflow early: got %b at word %0d required 0", overflow, i + 1);
                  end
               end
               tick();
            end
            in_valid = 1'b0;
            @(negedge clk);
            n_tests++;
            if (overflow !== 1'b1) begin
               n_fail++;
               $display("FAIL overflow set: got %b required 1", overflow);
            end
            tick();
            tick();
            m_axis_tready = 1'b1;
         end
         watch("overflow", 2000);
      join
      n_tests++;
      if (overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow sticky: got %b required 1", overflow);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle_outputs("overflow_clear");
   endtask

   task automatic test_random_ready();
      bit stop;
      stop = 1'b0;
      wq.delete();
      for (int i = 0; i < 800; i++) wq.push_back({$urandom, $urandom});
      model_beats(800);
      m_axis_tready = 1'b1;
      start_run(800);
      fork
         drive_words(1'b1);
         begin
            watch("random", 6000);
            stop = 1'b1;
         end
         begin
            for (int c = 0; c < 6000 && !stop; c++) begin
               @(posedge clk);
               #1;
               m_axis_tready = ($urandom_range(0, 1) == 1);
            end
         end
      join
      m_axis_tready = 1'b1;
      n_tests++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL random overflow: got %b required 0", overflow);
      end
   endtask

   task automatic test_zero_words();
      m_axis_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data  = 64'hDEAD_0000 + 64'(i);
         in_valid = 1'b1;
         @(negedge clk);
         n_tests++;
         if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero idle_input: got tvalid=%b busy=%b required 0 0", m_axis_tvalid, busy);
         end
         tick();
      end
      in_valid = 1'b0;
      cfg_num_words = 0;
      start = 1'b1;
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL zero done_c0: got %b required 0", done);
      end
      tick();
      start = 1'b0;
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL zero c1: got done=%b busy=%b required 0 1", done, busy);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero c2: got done=%b busy=%b tvalid=%b required 1 0 0", done, busy, m_axis_tvalid);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         @(negedge clk);
         n_tests++;
         if (done !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero after: got done=%b tvalid=%b required 0 0", done, m_axis_tvalid);
         end
      end
      tick();
   endtask

   task automatic test_reset_midrun();
      m_axis_tready = 1'b1;
      start_run(16);
      for (int i = 0; i < 5; i++) begin
         in_data  = 64'hBAD0_0000 + 64'(i);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      check_idle_outputs("midrun_reset");
      tick();
      rst = 1'b0;
      wq.delete();
      for (int i = 0; i < 8; i++) wq.push_back(64'h7700_0000_0000_0000 + 64'(i * 3 + 1));
      model_beats(8);
      start_run(8);
      fork
         drive_words(1'b0);
         watch("midrun_restart", 200);
      join
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      rst = 1'b1;
      cfg_num_words = '0;
      start = 1'b0;
      in_data = '0;
      in_valid = 1'b0;
      m_axis_tready = 1'b0;
      test_reset();
      test_basic16();
      test_partial10();
      test_overflow();
      test_random_ready();
      test_zero_words();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
